// File: rtl/native_pkg.sv
// Shared widths, the queued native command record and the responder FSM states
// used by the native-port memory responder.
package native_pkg;

  localparam int DDR_DATA_W = 256;
  localparam int DDR_MASK_W = DDR_DATA_W / 8;
  localparam int DDR_ADDR_W = 24;

  typedef struct packed {
    logic [DDR_ADDR_W-1:0] addr;
    logic                  we;
    logic                  mw;
  } ncmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_e;

endpackage

// File: rtl/native_cmd_fifo.sv
// Synchronous FIFO of native commands; the head entry is visible on pop_data
// whenever empty is low, and pop advances past it.
module native_cmd_fifo
  import native_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_n,
  input  logic  push,
  input  ncmd_t push_data,
  input  logic  pop,
  output ncmd_t pop_data,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ncmd_t            entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = entries[rd_ptr];

  // NOTE: storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) entries[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/native_mem_responder.sv
// Native-port memory responder: queues burst commands, absorbs masked write
// beats into an on-chip array and streams read beats through a 2-entry skid buffer.
module native_mem_responder
  import native_pkg::*;
#(
  parameter int DATA_W     = DDR_DATA_W,
  parameter int MASK_W     = DDR_MASK_W,
  parameter int ADDR_W     = DDR_ADDR_W,
  parameter int BEATS      = 2,
  parameter int MEM_BURSTS = 256,
  parameter int CMDQ_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              ncmd_valid_i,
  output logic              ncmd_ready_o,
  input  logic [ADDR_W-1:0] ncmd_payload_addr_i,
  input  logic              ncmd_payload_we_i,
  input  logic              ncmd_payload_mw_i,
  input  logic              wdata_valid_i,
  output logic              wdata_ready_o,
  input  logic [DATA_W-1:0] wdata_payload_data_i,
  input  logic [MASK_W-1:0] wdata_payload_we_i,
  output logic              rdata_valid_o,
  input  logic              rdata_ready_i,
  output logic [DATA_W-1:0] rdata_payload_data_o,
  output logic              busy_o,
  output logic [15:0]       wr_cmd_cnt_o,
  output logic [15:0]       rd_cmd_cnt_o
);

  localparam int BURST_W = $clog2(MEM_BURSTS);
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WORDS   = MEM_BURSTS * BEATS;

  state_e               state, state_nxt;
  ncmd_t                cmd_in, head;
  logic                 q_full, q_empty, push, pop;
  logic [BURST_W-1:0]   cur_addr;
  logic                 cur_mw;
  logic [BEAT_W-1:0]    beat;
  logic                 last_beat, wr_fire, rd_issue, rd_fire;
  logic                 inflight, inflight_last;
  logic [DATA_W-1:0]    rd_q;
  logic [DATA_W-1:0]    skid_data [2];
  logic                 skid_last [2];
  logic                 wr_sel, rd_sel;
  logic [1:0]           occ;
  logic [2:0]           credits;
  logic                 unused_addr_hi;

  assign cmd_in         = '{addr: DDR_ADDR_W'(ncmd_payload_addr_i),
                            we:   ncmd_payload_we_i,
                            mw:   ncmd_payload_mw_i};
  assign ncmd_ready_o   = ~q_full;
  assign push           = ncmd_valid_i & ~q_full;
  assign unused_addr_hi = ^head.addr[DDR_ADDR_W-1:BURST_W];

  native_cmd_fifo #(.DEPTH(CMDQ_DEPTH)) u_cmd_fifo (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign wr_fire   = wdata_valid_i & wdata_ready_o;
  assign rd_fire   = rdata_valid_o & rdata_ready_i;
  assign credits   = 3'(occ) + 3'(inflight);
  assign busy_o    = ~q_empty | (state != ST_IDLE);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    wdata_ready_o = 1'b0;
    rd_issue      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          pop       = 1'b1;
          state_nxt = head.we ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i && last_beat) state_nxt = ST_IDLE;
      end
      ST_READ: begin
        rd_issue = (credits < 3'd2);
        if (rd_issue && last_beat) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cur_addr     <= '0;
      cur_mw       <= 1'b0;
      beat         <= '0;
      wr_cmd_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        cur_addr <= head.addr[BURST_W-1:0];
        cur_mw   <= head.mw;
        beat     <= '0;
      end else if (wr_fire || rd_issue) begin
        beat <= beat + 1'b1;
      end
      if (wr_fire && last_beat) wr_cmd_cnt_o <= wr_cmd_cnt_o + 16'd1;
    end
  end

  logic [DATA_W-1:0]         mem [WORDS];
  logic [BURST_W+BEAT_W-1:0] word_idx;
  assign word_idx = {cur_addr, beat};

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!cur_mw || wdata_payload_we_i[b])
          mem[word_idx][b*8 +: 8] <= wdata_payload_data_i[b*8 +: 8];
      end
    end
    if (rd_issue) rd_q <= mem[word_idx];
  end

  // Issued reads are counted as credits until they leave the skid buffer,
  // so the buffer can never be asked to hold a third beat.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      skid_data[0]  <= '0;
      skid_data[1]  <= '0;
      skid_last[0]  <= 1'b0;
      skid_last[1]  <= 1'b0;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      occ           <= '0;
      rd_cmd_cnt_o  <= '0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue & last_beat;
      if (inflight) begin
        skid_data[wr_sel] <= rd_q;
        skid_last[wr_sel] <= inflight_last;
        wr_sel            <= ~wr_sel;
      end
      if (rd_fire) begin
        rd_sel <= ~rd_sel;
        if (skid_last[rd_sel]) rd_cmd_cnt_o <= rd_cmd_cnt_o + 16'd1;
      end
      case ({inflight, rd_fire})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign rdata_valid_o        = (occ != 2'd0);
  assign rdata_payload_data_o = skid_data[rd_sel];

endmodule
